pcie_rd_ort: RTL
================

// Module: pcie_rd_ort
// PURPOSE
//  Outstanding Read Table for the DMA PCIe read path. Supplies free 4-bit tags to pcie_tx_rd and records
//  iface/mem/local addr per issued read. Resolves completions from the RX completion parser into a local write
//  target, advancing the address as completions arrive. Frees tags on the last completion or on completion timeout.
// PARAMETERS
//  NUM_TAGS       16             table depth; fixed to the 4-bit PCIe tag field
//  MEM_ADDR_BITS  `MEM_ADDR_BITS local memory address width, DW granularity
//  TICK_CYCLES    1024           pcie_clk cycles per age tick
//  TIMEOUT_TICKS  15             age (ticks) at which an entry expires; 1..15
// PORTS
//  pcie_clk        in   1    sole clock
//  rst             in   1    synchronous, active-high reset
//  ort_req_v       in   1    record request (1-cycle pulse from pcie_tx_rd)
//  ort_req_tag     in   4    tag issued
//  ort_req_iface   in   2    target interface
//  ort_req_mem     in   4    target memory select
//  ort_req_addr    in   MEM_ADDR_BITS  local start address (DW)
//  ort_next_tag_v  out  1    a free tag exists
//  ort_next_tag    out  4    lowest-index free tag
//  cpl_v           in   1    completion header accepted
//  cpl_tag         in   4    completion tag
//  cpl_dw          in   11   DWs carried by this completion, 1..1024
//  cpl_last        in   1    final completion of the request
//  cpl_out_v       out  1    lookup result valid
//  cpl_out_iface   out  2    looked-up iface
//  cpl_out_mem     out  4    looked-up mem
//  cpl_out_addr    out  MEM_ADDR_BITS  write address for this completion's data
//  cpl_out_err     out  1    completion hit a non-busy tag
//  timeout_v       out  1    entry expired (pulse)
//  timeout_tag     out  4    expired tag
//  alloc_err       out  1    ort_req_v hit an already-busy tag (pulse)
//  busy_cnt        out  5    number of busy entries, 0..16
// BEHAVIOUR
//  - Reset: all entries free, ages 0, prescaler 0. Registered outputs 0: cpl_out_*, timeout_*, alloc_err.
//    busy_cnt=0. ort_next_tag_v=1, ort_next_tag=0.
//  - Free tag: combinational lowest-set-bit of free = ~busy & ~(ort_req_v ? onehot(ort_req_tag) : 0).
//    The bypass is mandatory: pcie_tx_rd samples ort_next_tag in the same cycle ort_req_v is asserted,
//    and must not receive that tag again. Tags freed in cycle N are offered from N+1.
//  - Allocate (ort_req_v): entry <= {iface,mem,addr}, busy<=1, age<=0 at the next edge.
//    If the entry is already busy: overwrite, alloc_err=1 for one cycle.
//  - Completion (cpl_v): lookup uses pre-edge state; results are registered, latency 1.
//    Busy tag: cpl_out_v=1, err=0. cpl_out_addr = stored addr; stored addr <= addr + cpl_dw,
//    mod 2^MEM_ADDR_BITS (wraps silently). age<=0.
//    If cpl_last=1: free the entry.
//    Free tag: cpl_out_v=1, err=1, other cpl_out_* = 0, table unchanged.
//  - Same cycle ort_req_v and cpl_v on one tag: the completion sees the old state; the allocation's write wins.
//  - Ageing: prescaler counts 0..TICK_CYCLES-1. On wrap, every busy entry's age increments, saturating at
//    TIMEOUT_TICKS. Each cycle the lowest-index entry with age==TIMEOUT_TICKS is freed, and timeout_v/tag are
//    pulsed (registered, one per cycle). Others wait.
//  - Timeout vs completion on the same tag in the same cycle: the completion is served normally; no timeout.
//  - busy_cnt is registered. It is updated by +alloc (of a non-busy entry) −cpl_last free −timeout free
//    in the same edge.
//  - rst mid-operation: the table is cleared; in-flight completions afterwards report cpl_out_err.
// STRUCTURE
//  - dma_defs.vh: ORT_TAG_BITS=4, ORT_NUM_TAGS=16, and the ort_entry_t struct {iface[1:0], mem[3:0], addr}.
//  - Sub-module ort_prio_enc (16-bit lowest-set-bit to {valid, idx[3:0]}), instanced for free-tag and
//    timeout select.
// TESTING
//  - Reset, then ort_req_v tag0 (addr 0x100) in the same cycle as sampling -> ort_next_tag=1 that cycle;
//    busy_cnt=1 next.
//  - Allocate all 16 -> ort_next_tag_v=0. Then cpl_last on tag 5 -> next cycle ort_next_tag_v=1, tag=5.
//  - Tag3 addr 0x200: cpl_dw=16 (not last), then cpl_dw=8 last -> cpl_out_addr 0x200, then 0x210;
//    tag3 freed.
//  - cpl_v on a free tag 7 -> cpl_out_v=1, cpl_out_err=1; busy_cnt unchanged.
//  - TICK_CYCLES=4, TIMEOUT_TICKS=2: allocate tags 0 and 1 in the same tick -> timeout_v tag0 and tag1
//    on consecutive cycles after 2 ticks; busy_cnt→0.
//  - Address wrap: addr = 2^MEM_ADDR_BITS−4 with cpl_dw=8 -> next cpl_out_addr=4. Also: re-allocate busy tag
//    -> alloc_err pulse.

Source files
------------

// File: rtl/pcie_rd_ort_pkg.sv
// Shared tag-table definitions for the PCIe read-path Outstanding Read Table.
package pcie_rd_ort_pkg;

  localparam int ORT_TAG_BITS = 4;
  localparam int ORT_NUM_TAGS = 16;
  localparam int ORT_AGE_BITS = 4;
  localparam int ORT_CNT_BITS = 5;
  localparam int ORT_DW_BITS  = 11;

  typedef struct packed {
    logic [1:0] iface;
    logic [3:0] mem;
  } ort_meta_t;

  function automatic logic [ORT_NUM_TAGS-1:0] tag_onehot(input logic [ORT_TAG_BITS-1:0] tag);
    logic [ORT_NUM_TAGS-1:0] oh;
    oh      = '0;
    oh[tag] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pcie_rd_ort_prio_enc.sv
// Lowest-set-bit encoder over the tag vector: returns whether any bit is set and its index.
module pcie_rd_ort_prio_enc
  import pcie_rd_ort_pkg::*;
(
  input  logic [ORT_NUM_TAGS-1:0] req,
  output logic                    valid,
  output logic [ORT_TAG_BITS-1:0] idx
);

  // Scanning downwards lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = ORT_NUM_TAGS - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ORT_TAG_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/pcie_rd_ort.sv
// Outstanding Read Table: hands out free tags, records each read's local target and
// resolves completions into write addresses, freeing tags on last completion or timeout.
module pcie_rd_ort
  import pcie_rd_ort_pkg::*;
#(
  parameter int NUM_TAGS      = ORT_NUM_TAGS,
  parameter int MEM_ADDR_BITS = 16,
  parameter int TICK_CYCLES   = 1024,
  parameter int TIMEOUT_TICKS = 15
) (
  input  logic                     pcie_clk,
  input  logic                     rst,
  input  logic                     ort_req_v,
  input  logic [3:0]               ort_req_tag,
  input  logic [1:0]               ort_req_iface,
  input  logic [3:0]               ort_req_mem,
  input  logic [MEM_ADDR_BITS-1:0] ort_req_addr,
  output logic                     ort_next_tag_v,
  output logic [3:0]               ort_next_tag,
  input  logic                     cpl_v,
  input  logic [3:0]               cpl_tag,
  input  logic [10:0]              cpl_dw,
  input  logic                     cpl_last,
  output logic                     cpl_out_v,
  output logic [1:0]               cpl_out_iface,
  output logic [3:0]               cpl_out_mem,
  output logic [MEM_ADDR_BITS-1:0] cpl_out_addr,
  output logic                     cpl_out_err,
  output logic                     timeout_v,
  output logic [3:0]               timeout_tag,
  output logic                     alloc_err,
  output logic [4:0]               busy_cnt
);

  localparam int PRESC_BITS = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [ORT_AGE_BITS-1:0] AGE_MAX = ORT_AGE_BITS'(TIMEOUT_TICKS);
  localparam logic [PRESC_BITS-1:0]   PRESC_LAST = PRESC_BITS'(TICK_CYCLES - 1);

  typedef struct packed {
    ort_meta_t                meta;
    logic [MEM_ADDR_BITS-1:0] addr;
  } ort_entry_t;

  ort_entry_t              entry_q [NUM_TAGS];
  logic [ORT_AGE_BITS-1:0] age_q   [NUM_TAGS];
  logic [NUM_TAGS-1:0]     busy_q;
  logic [PRESC_BITS-1:0]   presc_q;

  logic [NUM_TAGS-1:0]     req_mask;
  logic [NUM_TAGS-1:0]     cpl_mask;
  logic [NUM_TAGS-1:0]     free_vec;
  logic [NUM_TAGS-1:0]     expired_vec;
  logic [NUM_TAGS-1:0]     expire_cand;
  logic [NUM_TAGS-1:0]     to_mask;
  logic [NUM_TAGS-1:0]     last_mask;
  logic [NUM_TAGS-1:0]     busy_nxt;
  logic                    cpl_hit;
  logic                    tick;
  logic                    to_sel_v;
  logic [ORT_TAG_BITS-1:0] to_sel_idx;
  logic                    alloc_new;
  logic                    cpl_free;
  logic [MEM_ADDR_BITS-1:0] dw_ext;

  // The tag being allocated this cycle is hidden so pcie_tx_rd never sees it offered twice.
  always_comb begin
    req_mask    = ort_req_v ? tag_onehot(ort_req_tag) : '0;
    cpl_hit     = cpl_v & busy_q[cpl_tag];
    cpl_mask    = cpl_hit ? tag_onehot(cpl_tag) : '0;
    last_mask   = cpl_last ? cpl_mask : '0;
    free_vec    = ~busy_q & ~req_mask;
    tick        = (presc_q == PRESC_LAST);
    dw_ext      = MEM_ADDR_BITS'(cpl_dw);
    expired_vec = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      expired_vec[i] = busy_q[i] && (age_q[i] == AGE_MAX);
    end
    expire_cand = expired_vec & ~cpl_mask & ~req_mask;
  end

  pcie_rd_ort_prio_enc u_free_enc (
    .req   (free_vec),
    .valid (ort_next_tag_v),
    .idx   (ort_next_tag)
  );

  pcie_rd_ort_prio_enc u_timeout_enc (
    .req   (expire_cand),
    .valid (to_sel_v),
    .idx   (to_sel_idx)
  );

  // An allocation on the same tag as a last completion keeps the entry busy.
  always_comb begin
    to_mask   = to_sel_v ? tag_onehot(to_sel_idx) : '0;
    busy_nxt  = (busy_q & ~last_mask & ~to_mask) | req_mask;
    alloc_new = ort_req_v & ~busy_q[ort_req_tag];
    cpl_free  = cpl_hit & cpl_last & ~(ort_req_v && (ort_req_tag == cpl_tag));
  end

  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      busy_q  <= '0;
      presc_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        entry_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_nxt;
      presc_q <= tick ? '0 : presc_q + PRESC_BITS'(1);
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (req_mask[i]) begin
          entry_q[i] <= {ort_req_iface, ort_req_mem, ort_req_addr};
          age_q[i]   <= '0;
        end else if (cpl_mask[i]) begin
          entry_q[i].addr <= entry_q[i].addr + dw_ext;
          age_q[i]        <= '0;
        end else if (tick && busy_q[i] && (age_q[i] != AGE_MAX)) begin
          age_q[i] <= age_q[i] + ORT_AGE_BITS'(1);
        end
      end
    end
  end

  // Completion lookups see the pre-edge table, so results appear one cycle later.
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      cpl_out_v     <= 1'b0;
      cpl_out_iface <= '0;
      cpl_out_mem   <= '0;
      cpl_out_addr  <= '0;
      cpl_out_err   <= 1'b0;
      timeout_v     <= 1'b0;
      timeout_tag   <= '0;
      alloc_err     <= 1'b0;
      busy_cnt      <= '0;
    end else begin
      cpl_out_v     <= cpl_v;
      cpl_out_err   <= cpl_v & ~busy_q[cpl_tag];
      cpl_out_iface <= cpl_hit ? entry_q[cpl_tag].meta.iface : '0;
      cpl_out_mem   <= cpl_hit ? entry_q[cpl_tag].meta.mem : '0;
      cpl_out_addr  <= cpl_hit ? entry_q[cpl_tag].addr : '0;
      timeout_v     <= to_sel_v;
      timeout_tag   <= to_sel_v ? to_sel_idx : '0;
      alloc_err     <= ort_req_v & busy_q[ort_req_tag];
      busy_cnt      <= busy_cnt + ORT_CNT_BITS'(alloc_new)
                       - ORT_CNT_BITS'(cpl_free) - ORT_CNT_BITS'(to_sel_v);
    end
  end

endmodule
